// File: rtl/bus_endpoint_rx.sv
// bus_endpoint_rx
//   Target-side receiver for the control unit's byte-wide data bus. Each frame
//   is one header byte followed by ADDRW/8 address bytes, MSB first. A good
//   frame is presented as a command for the addressed target (mem, aes or sha).
//   The endpoint then waits for that target's completion strobe and returns a
//   one-cycle pulse on the matching bit of the ack vector. A malformed header
//   is consumed in full and reported through err_out/err_code. An address
//   stream that stalls for TIMEOUT cycles is aborted and also reported.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   data_in      bus byte from the arbiter, qualified by data_valid
//   bus_ready    endpoint can accept a byte (registered; high in IDLE/ADDR)
//   cmd_valid    decoded command valid, held until cmd_ready
//   cmd_ready    downstream accepts the command
//   cmd_op       header[7:6]: 00 key-read, 01 text-read, 10 dest-write, 11 hash-read
//   cmd_target   header[5:4]: 0 mem, 1 aes, 2 sha
//   cmd_addr     assembled address
//   done_in      completion strobes, one bit per target
//   ack_out      one-cycle ack pulse, bit index equals target
//   err_out      one-cycle error pulse
//   err_code     01 bad header, 10 timeout; holds until the next error

module bus_endpoint_rx #(
  parameter int unsigned ADDRW   = 24,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             bus_ready,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [1:0]       cmd_op,
  output logic [1:0]       cmd_target,
  output logic [ADDRW-1:0] cmd_addr,
  input  logic [2:0]       done_in,
  output logic [2:0]       ack_out,
  output logic             err_out,
  output logic [1:0]       err_code
);

  localparam int unsigned NBYTES = ADDRW / 8;
  localparam int unsigned BW     = (NBYTES > 1) ? $clog2(NBYTES + 1) : 1;
  localparam int unsigned TW     = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
  localparam logic [TW-1:0] TMO_LIM   = TW'(TIMEOUT);

  localparam logic [1:0] ERR_BAD_HDR = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ISSUE,
    S_BUSY,
    S_ACK
  } state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             bad_q, bad_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic             bus_ready_q, bus_ready_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [2:0]       ack_q, ack_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic             xfer;
  logic             done_hit;
  logic [2:0]       tgt_onehot;
  logic [ADDRW+7:0] addr_shift;

  // bus_ready is registered, so a transfer is judged against the value
  // the arbiter saw during this cycle.
  assign xfer = data_valid && bus_ready_q;

  // Dropping the top byte of the wide concatenation gives the MSB-first
  // shift without slicing cmd_addr, which also keeps ADDRW == 8 legal.
  assign addr_shift = {addr_q, data_in};

  // Only the addressed target's strobe matters; a target code of 3 never
  // reaches BUSY because such headers are rejected.
  always_comb begin
    done_hit   = 1'b0;
    tgt_onehot = '0;
    unique case (tgt_q)
      2'd0: begin done_hit = done_in[0]; tgt_onehot = 3'b001; end
      2'd1: begin done_hit = done_in[1]; tgt_onehot = 3'b010; end
      2'd2: begin done_hit = done_in[2]; tgt_onehot = 3'b100; end
      default: begin done_hit = 1'b0; tgt_onehot = '0; end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    tmo_d      = tmo_q;
    bad_d      = bad_q;
    op_d       = op_q;
    tgt_d      = tgt_q;
    addr_d     = addr_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    unique case (state_q)
      S_IDLE: begin
        byte_cnt_d = '0;
        tmo_d      = '0;
        if (xfer) begin
          op_d    = data_in[7:6];
          tgt_d   = data_in[5:4];
          bad_d   = (data_in[5:4] == 2'd3) || (data_in[3:0] != 4'd0);
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (xfer) begin
          addr_d = addr_shift[ADDRW-1:0];
          tmo_d  = '0;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            if (bad_q) begin
              err_d      = 1'b1;
              err_code_d = ERR_BAD_HDR;
              state_d    = S_IDLE;
            end else begin
              state_d    = S_ISSUE;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BW'(1);
          end
        end else begin
          tmo_d = (tmo_q == TMO_LIM) ? tmo_q : tmo_q + TW'(1);
          if (tmo_d == TMO_LIM) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = S_IDLE;
          end
        end
      end

      S_ISSUE: begin
        if (cmd_ready) begin
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        if (done_hit) begin
          state_d = S_ACK;
        end
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered decodes of the next state so they line up
    // with the state they describe.
    bus_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR);
    cmd_valid_d = (state_d == S_ISSUE);
    ack_d       = (state_d == S_ACK) ? tgt_onehot : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      tmo_q       <= '0;
      bad_q       <= 1'b0;
      op_q        <= '0;
      tgt_q       <= '0;
      addr_q      <= '0;
      bus_ready_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_q       <= tmo_d;
      bad_q       <= bad_d;
      op_q        <= op_d;
      tgt_q       <= tgt_d;
      addr_q      <= addr_d;
      bus_ready_q <= bus_ready_d;
      cmd_valid_q <= cmd_valid_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus_ready  = bus_ready_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_op     = op_q;
  assign cmd_target = tgt_q;
  assign cmd_addr   = addr_q;
  assign ack_out    = ack_q;
  assign err_out    = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_bus_endpoint_rx.sv
module tb_bus_endpoint_rx;

  localparam int unsigned ADDRW   = 24;
  localparam int unsigned TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       data_in = '0;
  logic             data_valid = 1'b0;
  logic             bus_ready;
  logic             cmd_valid;
  logic             cmd_ready = 1'b0;
  logic [1:0]       cmd_op;
  logic [1:0]       cmd_target;
  logic [ADDRW-1:0] cmd_addr;
  logic [2:0]       done_in = '0;
  logic [2:0]       ack_out;
  logic             err_out;
  logic [1:0]       err_code;

  bus_endpoint_rx #(.ADDRW(ADDRW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .bus_ready(bus_ready), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_target(cmd_target), .cmd_addr(cmd_addr),
    .done_in(done_in), .ack_out(ack_out), .err_out(err_out), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // kind: 0 = command handshake, 1 = ack pulse, 2 = error pulse
  typedef struct {
    int         kind;
    logic [1:0] op;
    logic [1:0] tgt;
    logic [23:0] addr;
    logic [2:0] ack;
    logic [1:0] code;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [1:0] tgt, input logic [23:0] addr);
    exp_t e;
    e.kind = 0; e.op = op; e.tgt = tgt; e.addr = addr; e.ack = '0; e.code = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_ack(input logic [2:0] a);
    exp_t e;
    e.kind = 1; e.op = '0; e.tgt = '0; e.addr = '0; e.ack = a; e.code = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] c);
    exp_t e;
    e.kind = 2; e.op = '0; e.tgt = '0; e.addr = '0; e.ack = '0; e.code = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d expected none (ack=%b err=%b) at %0t",
               kind, ack_out, err_out, $time);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (e.kind == kind) begin
        case (kind)
          0: begin
            chk("cmd_op", cmd_op, e.op);
            chk("cmd_target", cmd_target, e.tgt);
            chk("cmd_addr", cmd_addr, e.addr);
          end
          1: chk("ack_out", ack_out, e.ack);
          default: chk("err_code", err_code, e.code);
        endcase
      end
    end
  endtask

  // Monitor: decoupled from stimulus, samples away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid && cmd_ready) observe(0);
      if (ack_out != 3'b000)      observe(1);
      if (err_out)                observe(2);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic r;
    int n;
    data_valid = 1'b1;
    data_in    = b;
    n = 0;
    forever begin
      r = bus_ready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL bus_ready_wait: got 0 expected 1 within 50 cycles at %0t", $time);
        break;
      end
    end
    data_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [23:0] a);
    logic [23:0] av;
    av = a;
    send_byte(h);
    send_byte(av[23:16]);
    send_byte(av[15:8]);
    send_byte(av[7:0]);
  endtask

  task automatic pulse_done(input logic [2:0] d);
    done_in = d;
    cyc(1);
    done_in = '0;
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk("rst_bus_ready", bus_ready, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_ack", ack_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_addr", cmd_addr, 0);
    rst = 1'b0;
    cyc(1);
    chk("bus_ready_after_rst", bus_ready, 1);

    // Good frame, no stalls
    cmd_ready = 1'b1;
    push_cmd(2'b01, 2'd1, 24'h123456);
    send_frame(8'h50, 24'h123456);
    chk("t1_cmd_valid", cmd_valid, 1);
    cyc(1);
    push_ack(3'b010);
    pulse_done(3'b010);
    chk("t1_ack_next_cycle", ack_out, 3'b010);
    cyc(2);

    // Downstream backpressure
    cmd_ready = 1'b0;
    send_frame(8'h20, 24'hABCDEF);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) done_in = 3'b100;
      chk("bp_cmd_valid", cmd_valid, 1);
      chk("bp_bus_ready", bus_ready, 0);
      chk("bp_addr", cmd_addr, 24'hABCDEF);
      chk("bp_op_tgt", {cmd_op, cmd_target}, 4'b0010);
      cyc(1);
      done_in = '0;
    end
    push_cmd(2'b00, 2'd2, 24'hABCDEF);
    cmd_ready = 1'b1;
    cyc(1);
    cmd_ready = 1'b0;
    cyc(2);
    push_ack(3'b100);
    pulse_done(3'b100);
    cyc(2);

    // Bad header: all address bytes consumed, then err 01
    cmd_ready = 1'b1;
    push_err(2'b01);
    send_frame(8'h31, 24'h010203);
    chk("bad_err_pulse", err_out, 1);
    chk("bad_err_code", err_code, 2'b01);
    cyc(1);
    chk("bad_err_one_cycle", err_out, 0);
    chk("bad_err_code_hold", err_code, 2'b01);
    cyc(2);

    // Timeout after TIMEOUT idle cycles
    push_err(2'b10);
    send_byte(8'h80);
    send_byte(8'h01);
    cyc(TIMEOUT - 1);
    chk("tmo_not_early", err_out, 0);
    cyc(1);
    chk("tmo_err_pulse", err_out, 1);
    chk("tmo_err_code", err_code, 2'b10);
    chk("tmo_back_idle", bus_ready, 1);
    cyc(1);
    push_cmd(2'b10, 2'd0, 24'h000010);
    send_frame(8'h80, 24'h000010);
    chk("tmo_next_addr", cmd_addr, 24'h000010);
    cyc(1);
    push_ack(3'b001);
    pulse_done(3'b001);
    cyc(2);

    // Wrong-target done is ignored
    push_cmd(2'b10, 2'd1, 24'h00BEEF);
    send_frame(8'h90, 24'h00BEEF);
    cyc(1);
    pulse_done(3'b100);
    cyc(3);
    chk("wrong_tgt_no_ack", ack_out, 0);
    push_ack(3'b010);
    pulse_done(3'b010);
    cyc(2);

    // Reset mid-frame
    send_byte(8'hD0);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mrst_bus_ready", bus_ready, 0);
    chk("mrst_cmd_valid", cmd_valid, 0);
    chk("mrst_ack_err", {ack_out, err_out}, 0);
    chk("mrst_err_code", err_code, 0);
    chk("mrst_cmd_fields", {cmd_op, cmd_target, cmd_addr}, 0);
    cyc(1);
    chk("mrst_bus_ready_back", bus_ready, 1);
    cyc(TIMEOUT + 3);
    chk("mrst_no_err", err_code, 0);

    cyc(2);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/bus_endpoint_rx.md
Name: bus_endpoint_rx

Overview:
Target-side receiver for the control unit's byte-wide data bus. It accepts frames of one header byte plus ADDRW/8 address bytes (MSB first) from the bus arbiter output, decodes each frame into a command for the addressed target, and waits for that target to finish. It then returns a one-cycle pulse on the matching bit of the 3-bit ack vector the control FSMs consume. It is the responder end of the data_bus/ack interface and sits between the arbiter bus and the memory, AES and SHA cores.

Parameters:
ADDRW, 24, address width in bits; must be a multiple of 8; sets NBYTES = ADDRW/8.
TIMEOUT, 255, maximum idle cycles allowed between address bytes before a frame is aborted; must be at least 1.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
data_in  input  8  bus byte from the arbiter
data_valid  input  1  data_in valid
bus_ready  output  1  endpoint can accept a byte
cmd_valid  output  1  decoded command valid
cmd_ready  input  1  downstream accepts the command
cmd_op  output  2  header bits [7:6]: 00 key-read, 01 text-read, 10 dest-write, 11 hash-read
cmd_target  output  2  header bits [5:4]: 0 mem, 1 aes, 2 sha
cmd_addr  output  ADDRW  assembled address
done_in  input  3  completion strobes, one bit per target
ack_out  output  3  one-cycle ack pulse; bit index equals target
err_out  output  1  one-cycle error pulse
err_code  output  2  01 bad header, 10 timeout; holds its value until the next error

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. bus_ready=0, cmd_valid=0, cmd_op/cmd_target/cmd_addr=0, ack_out=0, err_out=0, err_code=0, byte and timeout counters=0. Reset aborts any frame in flight; no ack is issued for it.
- Byte transfer occurs only on an edge where data_valid && bus_ready. bus_ready is a registered state decode: 1 in IDLE and ADDR, 0 elsewhere. After reset it is 1 one cycle after rst deasserts.
- IDLE: on transfer, latch the header.
  - A header is bad if target==3 or bits[3:0]!=0. A bad header sets bad_flag.
  - Go to ADDR with byte_cnt=0 and tmo=0.
- ADDR:
  - On transfer: cmd_addr <= {cmd_addr[ADDRW-9:0], data_in}, byte_cnt++, tmo=0.
  - With no transfer: tmo++. If tmo reaches TIMEOUT, pulse err_out, set err_code=10 and go to IDLE. The partial frame is discarded.
  - On the transfer of byte NBYTES: if bad_flag, pulse err_out with err_code=01 on the next cycle and return to IDLE, with no cmd and no ack. Otherwise go to ISSUE.
- ISSUE: cmd_valid=1, and cmd_op/cmd_target/cmd_addr are held stable. cmd_valid rises the cycle after the last address byte is accepted. When cmd_valid && cmd_ready, drop cmd_valid and go to BUSY.
- BUSY: sample done_in[cmd_target] only.
  - done_in bits for other targets are ignored.
  - done_in asserted in any state other than BUSY is ignored. It is not remembered.
  - When done_in[cmd_target]=1, go to ACK.
- ACK: ack_out = 1<<cmd_target for exactly one cycle, then IDLE. The minimum gap from done_in to ack_out is 1 cycle.
- Throughput: one frame in flight. The next header can be accepted on the cycle after ACK.
- err_out and ack_out are never asserted in the same cycle.
- The timeout counter is sized clog2(TIMEOUT+1) and saturates; it never wraps. It counts only in ADDR.
- Simultaneous rst with any event: rst wins.

Test Plan:
- Good frame, no stalls. Stream 0x50, 0x12, 0x34, 0x56 (ADDRW=24) and hold cmd_ready=1. Required: cmd_valid for one cycle with op=01, target=1, addr=0x123456. Then drive done_in=3'b010: ack_out=3'b010 for exactly one cycle, the next cycle.
- Downstream backpressure. Header 0x20, address 0xABCDEF, cmd_ready held 0 for 5 cycles. Required: cmd_valid stays 1 with stable outputs and bus_ready stays 0. Raising done_in[2] during ISSUE produces no ack.
- Bad header 0x31. Required: all 3 address bytes are consumed, then err_out pulses with err_code=01. No cmd_valid and no ack_out.
- Timeout with TIMEOUT=4. Send header 0x80, then byte 0x01, then drop data_valid. Required: err_out pulses after 4 idle cycles with err_code=10, and the state is IDLE. A following good frame 0x80,0x00,0x00,0x10 produces cmd_addr=0x000010.
- Wrong-target done. Frame 0x90 (target 1) completes to BUSY and done_in=3'b100 is driven. Required: no ack. A later done_in=3'b010 produces ack_out=3'b010.
- Reset mid-frame. Assert rst for one cycle after 2 address bytes. Required: all outputs are 0 on the next cycle, bus_ready=1 one cycle later, and no err or ack results from the aborted frame.
